// File: rtl/ws2812_pkg.sv
// Shared state encoding, default WS2812 timing and sizing helpers for the
// RAM-fed eight-lane WS2812 reader and its bench.
package ws2812_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_SEND,
    ST_LATCH
  } state_e;

  localparam int T0H_DEF  = 20;
  localparam int T1H_DEF  = 40;
  localparam int TBIT_DEF = 63;
  localparam int RST_DEF  = 2600;

  localparam int LANES  = 8;
  localparam int WORD_W = 24;
  localparam int ADDR_W = 6;

  function automatic int cnt_width(input int tbit, input int rst);
    int m;
    m = (tbit > rst) ? tbit : rst;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ram_rd_ws2812_if.sv
// RAM read / writer handshake bundle between the WS2812 reader (master)
// and the layer RAMs plus write controller (slave).
interface ram_rd_ws2812_if;
  import ws2812_pkg::*;

  logic                      read;
  logic [LANES*WORD_W-1:0]   layer_data;
  logic                      rd_en;
  logic [ADDR_W-1:0]         rd_addr;
  logic                      trans;

  modport master (
    input  read,
    input  layer_data,
    output rd_en,
    output rd_addr,
    output trans
  );

  modport slave (
    output read,
    output layer_data,
    input  rd_en,
    input  rd_addr,
    input  trans
  );

endinterface

// File: rtl/ws2812_bit_enc.sv
// Shared bit-period counter: wraps at a selectable terminal count and
// reports whether the current cycle is inside a '0' or a '1' high phase.
module ws2812_bit_enc
  import ws2812_pkg::*;
#(
  parameter int T0H_CYC = T0H_DEF,
  parameter int T1H_CYC = T1H_DEF,
  parameter int CW      = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run_i,
  input  logic [CW-1:0] term_i,
  output logic [CW-1:0] cnt_o,
  output logic          done_o,
  output logic          hi0_o,
  output logic          hi1_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == term_i);
  assign hi0_o  = (cnt_q < CW'(T0H_CYC));
  assign hi1_o  = (cnt_q < CW'(T1H_CYC));
  assign cnt_o  = cnt_q;

  // Counter rests at zero whenever it is not running, so every period starts at 0.
  always_comb begin
    cnt_d = '0;
    if (run_i && !done_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_rd_ws2812.sv
// Reads 64 words from eight layer RAMs and streams them as eight
// bit-synchronous WS2812 lines, prefetching the next word during bit 0.
module ram_rd_ws2812
  import ws2812_pkg::*;
#(
  parameter int T0H_CYC  = T0H_DEF,
  parameter int T1H_CYC  = T1H_DEF,
  parameter int TBIT_CYC = TBIT_DEF,
  parameter int RST_CYC  = RST_DEF
) (
  input  logic              SCLK,
  input  logic              Rst_n,
  ram_rd_ws2812_if.master   ram,
  output logic [LANES-1:0]  DOUT
);

  localparam int              CW       = cnt_width(TBIT_CYC, RST_CYC);
  localparam logic [CW-1:0]   BIT_TERM = CW'(TBIT_CYC - 1);
  localparam logic [CW-1:0]   RST_TERM = CW'(RST_CYC - 1);
  localparam logic [4:0]      MSB_IDX  = 5'(WORD_W - 1);

  state_e                        state_q, state_d;
  logic [4:0]                    bit_q, bit_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [LANES-1:0][WORD_W-1:0]  shift_q, shift_d;
  logic [LANES-1:0][WORD_W-1:0]  hold_q, hold_d;
  logic [LANES-1:0]              dout_q, dout_d;

  logic          rd_en;
  logic          prefetch;
  logic          enc_run;
  logic [CW-1:0] enc_term;
  logic [CW-1:0] enc_cnt;
  logic          enc_done;
  logic          hi0, hi1;

  ws2812_bit_enc #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .CW      (CW)
  ) u_enc (
    .clk    (SCLK),
    .rst_n  (Rst_n),
    .run_i  (enc_run),
    .term_i (enc_term),
    .cnt_o  (enc_cnt),
    .done_o (enc_done),
    .hi0_o  (hi0),
    .hi1_o  (hi1)
  );

  assign enc_run  = (state_q == ST_SEND) || (state_q == ST_LATCH);
  assign enc_term = (state_q == ST_LATCH) ? RST_TERM : BIT_TERM;

  // During bit 0 the address already points at the next word; 0 there means word 63 is ending.
  assign prefetch = (state_q == ST_SEND) && (bit_q == '0) && (enc_cnt == '0) && (addr_q != '0);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    rd_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ram.read) begin
          state_d = ST_FETCH;
          addr_d  = '0;
        end
      end
      ST_FETCH: begin
        rd_en   = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        shift_d = ram.layer_data;
        bit_d   = MSB_IDX;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        rd_en = prefetch;
        if ((bit_q == '0) && (enc_cnt == CW'(1))) begin
          hold_d = ram.layer_data;
        end
        if (enc_done) begin
          if (bit_q == 5'd1) begin
            addr_d = addr_q + 1'b1;
          end
          if (bit_q != '0) begin
            bit_d = bit_q - 1'b1;
            for (int k = 0; k < LANES; k++) begin
              shift_d[k] = {shift_q[k][WORD_W-2:0], 1'b0};
            end
          end else if (addr_q == '0) begin
            state_d = ST_LATCH;
          end else begin
            shift_d = hold_q;
            bit_d   = MSB_IDX;
          end
        end
      end
      ST_LATCH: begin
        if (enc_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign dout_d[gi] = (state_q == ST_SEND) && (shift_q[gi][WORD_W-1] ? hi1 : hi0);
    end
  endgenerate

  always_ff @(posedge SCLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      addr_q  <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      dout_q  <= dout_d;
    end
  end

  assign DOUT        = dout_q;
  assign ram.rd_en   = rd_en;
  assign ram.rd_addr = addr_q;
  assign ram.trans   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_rd_ws2812.sv
// Directed bench for ram_rd_ws2812: a RAM model feeds patterns, a per-lane
// decoder rebuilds the 24-bit words and frame timing from DOUT.
module tb_ram_rd_ws2812;
  import ws2812_pkg::*;

  localparam int T0H    = 2;
  localparam int T1H    = 4;
  localparam int TBIT   = 6;
  localparam int RST    = 30;
  localparam int NBITS  = 64 * WORD_W;
  localparam int NSEND  = NBITS * TBIT;
  localparam int BUDGET = NSEND + RST + 200;

  logic             SCLK = 1'b0;
  logic             Rst_n;
  logic [LANES-1:0] DOUT;

  ram_rd_ws2812_if ram ();

  ram_rd_ws2812 #(
    .T0H_CYC  (T0H),
    .T1H_CYC  (T1H),
    .TBIT_CYC (TBIT),
    .RST_CYC  (RST)
  ) dut (
    .SCLK  (SCLK),
    .Rst_n (Rst_n),
    .ram   (ram),
    .DOUT  (DOUT)
  );

  always #5 SCLK = ~SCLK;

  typedef struct {
    int          frm;
    int          lane;
    int          word;
    logic [23:0] want;
  } vec_t;

  vec_t tbl [16];

  int errors = 0;
  int checks = 0;
  int mode   = 0;
  bit mon_clr = 1'b0;

  // RAM model: one-cycle read latency, pattern chosen by mode.
  function automatic logic [23:0] word_of(input int md, input int k, input logic [5:0] a);
    logic [7:0] a8;
    a8 = {2'b00, a};
    case (md)
      0:       return 24'hFF0000;
      1:       return {a8, 8'(k), a8 ^ 8'h5A};
      default: return 24'h000001 << k;
    endcase
  endfunction

  always @(posedge SCLK) begin
    if (ram.rd_en) begin
      for (int k = 0; k < LANES; k++) begin
        ram.layer_data[WORD_W*k +: WORD_W] <= word_of(mode, k, ram.rd_addr);
      end
    end
  end

  // Line decoder and frame monitor, sampled on the falling edge.
  int               ncyc = 0;
  logic [23:0]      cap [LANES][64];
  int               nbits [LANES];
  int               hi_len [LANES];
  int               lo_len [LANES];
  logic [LANES-1:0] prev = '0;
  logic             prev_trans = 1'b0;
  int hi_err = 0, per_err = 0, rdcnt = 0, addr_err = 0, trans_rises = 0;
  int t_rise = 0, t_fall = 0, t_first = 0;

  always @(negedge SCLK) begin
    int   e_hi;
    int   e_per;
    logic b;
    e_hi  = 0;
    e_per = 0;
    ncyc <= ncyc + 1;
    if (mon_clr) begin
      for (int k = 0; k < LANES; k++) begin
        nbits[k]  <= 0;
        hi_len[k] <= 0;
        lo_len[k] <= 0;
        for (int w = 0; w < 64; w++) cap[k][w] <= '0;
      end
      prev        <= DOUT;
      prev_trans  <= ram.trans;
      hi_err      <= 0;
      per_err     <= 0;
      rdcnt       <= 0;
      addr_err    <= 0;
      trans_rises <= 0;
      t_rise      <= 0;
      t_fall      <= 0;
      t_first     <= 0;
    end else begin
      prev       <= DOUT;
      prev_trans <= ram.trans;
      if (ram.trans && !prev_trans) begin
        trans_rises <= trans_rises + 1;
        t_rise      <= ncyc;
      end
      if (!ram.trans && prev_trans) t_fall <= ncyc;
      if (ram.rd_en) begin
        if (ram.rd_addr != 6'(rdcnt)) addr_err <= addr_err + 1;
        rdcnt <= rdcnt + 1;
      end
      for (int k = 0; k < LANES; k++) begin
        if (DOUT[k] && !prev[k]) begin
          if (nbits[k] > 0 && (hi_len[k] + lo_len[k]) != TBIT) e_per++;
          if (k == 0 && nbits[0] == 0) t_first <= ncyc;
          hi_len[k] <= 1;
          lo_len[k] <= 0;
        end else if (DOUT[k]) begin
          hi_len[k] <= hi_len[k] + 1;
        end else if (prev[k]) begin
          b = (hi_len[k] == T1H);
          if (hi_len[k] != T1H && hi_len[k] != T0H) e_hi++;
          if (nbits[k] < NBITS)
            cap[k][nbits[k]/WORD_W] <= {cap[k][nbits[k]/WORD_W][22:0], b};
          nbits[k]  <= nbits[k] + 1;
          lo_len[k] <= 1;
        end else begin
          lo_len[k] <= lo_len[k] + 1;
        end
      end
      hi_err  <= hi_err + e_hi;
      per_err <= per_err + e_per;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic clear_mon();
    @(negedge SCLK);
    #1 mon_clr = 1'b1;
    @(negedge SCLK);
    #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_read();
    @(negedge SCLK);
    ram.read = 1'b1;
    @(negedge SCLK);
    ram.read = 1'b0;
  endtask

  task automatic wait_trans(input logic lvl, input int budget, input string name);
    int n;
    n = 0;
    while (ram.trans !== lvl && n < budget) begin
      @(negedge SCLK);
      n++;
    end
    check(name, 32'(ram.trans), 32'(lvl));
  endtask

  task automatic wait_bits(input int nb, input string name);
    int n;
    n = 0;
    while (nbits[0] < nb && n < BUDGET) begin
      @(negedge SCLK);
      n++;
    end
    check(name, 32'(nbits[0] >= nb), 32'd1);
  endtask

  task automatic frame_checks(input int frm);
    for (int k = 0; k < LANES; k++)
      check($sformatf("f%0d lane%0d bit count", frm, k), 32'(nbits[k]), 32'(NBITS));
    check($sformatf("f%0d period errors", frm), 32'(per_err), 32'd0);
    check($sformatf("f%0d high-time errors", frm), 32'(hi_err), 32'd0);
    check($sformatf("f%0d rd_en count", frm), 32'(rdcnt), 32'd64);
    check($sformatf("f%0d rd_addr order errors", frm), 32'(addr_err), 32'd0);
    // FETCH + WAIT + send + latch; DOUT trails state by its output register.
    check($sformatf("f%0d trans length", frm), 32'(t_fall - t_rise), 32'(NSEND + RST + 2));
    check($sformatf("f%0d first DOUT latency", frm), 32'(t_first - t_rise), 32'd3);
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].frm == frm)
        check($sformatf("f%0d lane%0d word%0d", frm, tbl[i].lane, tbl[i].word),
              32'(cap[tbl[i].lane][tbl[i].word]), 32'(tbl[i].want));
    end
  endtask

  task automatic run_frame(input int md, input int frm);
    clear_mon();
    mode = md;
    pulse_read();
    wait_trans(1'b1, 5, $sformatf("f%0d trans rise", frm));
    wait_trans(1'b0, BUDGET, $sformatf("f%0d trans fall", frm));
    repeat (3) @(negedge SCLK);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 0, 0,  24'hFF0000};
    tbl[1]  = '{0, 7, 0,  24'hFF0000};
    tbl[2]  = '{0, 3, 63, 24'hFF0000};
    tbl[3]  = '{1, 0, 0,  24'h00005A};
    tbl[4]  = '{1, 3, 5,  24'h05035F};
    tbl[5]  = '{1, 7, 63, 24'h3F0765};
    tbl[6]  = '{1, 5, 31, 24'h1F0545};
    tbl[7]  = '{1, 2, 32, 24'h20027A};
    tbl[8]  = '{2, 0, 10, 24'h000001};
    tbl[9]  = '{2, 4, 0,  24'h000010};
    tbl[10] = '{2, 7, 63, 24'h000080};
    tbl[11] = '{2, 6, 40, 24'h000040};
    tbl[12] = '{2, 3, 17, 24'h000008};
    tbl[13] = '{3, 1, 0,  24'h00015A};
    tbl[14] = '{3, 6, 30, 24'h1E0644};
    tbl[15] = '{3, 4, 63, 24'h3F0465};

    Rst_n    = 1'b0;
    ram.read = 1'b0;
    repeat (3) @(negedge SCLK);
    check("reset DOUT", 32'(DOUT), 32'd0);
    check("reset trans", 32'(ram.trans), 32'd0);
    check("reset rd_en", 32'(ram.rd_en), 32'd0);
    check("reset rd_addr", 32'(ram.rd_addr), 32'd0);
    Rst_n = 1'b1;
    repeat (2) @(negedge SCLK);

    // Frame 0: FF0000 everywhere, first byte ones then zeros.
    run_frame(0, 0);
    frame_checks(0);

    // Frame 1: address-valued data.
    run_frame(1, 1);
    frame_checks(1);
    check("idle after frame rd_addr", 32'(ram.rd_addr), 32'd0);

    // Frame 2: one-hot per layer, plus a read pulse at bit 100 that must be ignored.
    clear_mon();
    mode = 2;
    pulse_read();
    wait_bits(100, "f2 reached bit 100");
    pulse_read();
    wait_trans(1'b0, BUDGET, "f2 trans fall");
    repeat (40) @(negedge SCLK);
    check("f2 single trans rise", 32'(trans_rises), 32'd1);
    check("f2 stays idle", 32'(ram.trans), 32'd0);
    frame_checks(2);

    // Frame 3: reset during word 30, then a clean restart.
    clear_mon();
    mode = 1;
    pulse_read();
    wait_bits(30 * WORD_W + 5, "mid-frame reached word 30");
    @(negedge SCLK);
    #2 Rst_n = 1'b0;
    #1;
    check("async reset DOUT", 32'(DOUT), 32'd0);
    check("async reset trans", 32'(ram.trans), 32'd0);
    check("async reset rd_addr", 32'(ram.rd_addr), 32'd0);
    check("async reset rd_en", 32'(ram.rd_en), 32'd0);
    repeat (3) @(negedge SCLK);
    Rst_n = 1'b1;
    repeat (50) @(negedge SCLK);
    check("no resume trans", 32'(ram.trans), 32'd0);
    check("no resume DOUT", 32'(DOUT), 32'd0);
    run_frame(1, 3);
    frame_checks(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_rd_ws2812.md
RAM_RD_WS2812 -- requirements
Module: ram_rd_ws2812

Interface
REQ-001 SHALL have parameter T0H_CYC, default 20, meaning high time of a '0' bit in SCLK cycles.
REQ-002 SHALL have parameter T1H_CYC, default 40, meaning high time of a '1' bit in SCLK cycles.
REQ-003 SHALL have parameter TBIT_CYC, default 63, meaning total bit period in SCLK cycles; T0H_CYC < T1H_CYC < TBIT_CYC.
REQ-004 SHALL have parameter RST_CYC, default 2600, meaning latch (reset) low time after a frame, in SCLK cycles.
REQ-005 SCLK  input  1  system clock; single clock domain.
REQ-006 Rst_n  input  1  asynchronous active-low reset.
REQ-007 read  input  1  one-cycle start pulse from the RAM write controller.
REQ-008 layer_data  input  192  eight 24-bit RAM read words; layer k on bits [24k+23:24k]; valid one cycle after rd_en.
REQ-009 rd_en  output  1  RAM read strobe, applied to all eight layer RAMs together.
REQ-010 rd_addr  output  6  RAM read address, 0..63.
REQ-011 DOUT  output  8  WS2812 serial line per layer; DOUT[k] drives layer k.
REQ-012 trans  output  1  busy; high while a frame is being sent; feeds the writer's trans input.

Function
REQ-013 States: IDLE, FETCH, WAIT, SEND, LATCH.
REQ-014 IDLE: read=1 -> FETCH, rd_addr=0, trans=1 on the next cycle; read=0 -> stay.
REQ-015 FETCH: rd_en=1 for exactly one cycle with current rd_addr -> WAIT.
REQ-016 WAIT: capture layer_data into eight 24-bit shift registers, bit counter=23 -> SEND.
REQ-017 SEND: each bit lasts exactly TBIT_CYC cycles; DOUT[k] high for T1H_CYC cycles if shift[k] MSB=1, else for T0H_CYC cycles, then low for the rest of the period.
REQ-018 Bit order: bit 23 first, bit 0 last; bytes go out in stored order (G,R,B).
REQ-019 Prefetch: at the start of bit 0, rd_en pulses for address rd_addr+1 and the result is held in a holding register, so there is no gap between bit 0 of word n and bit 23 of word n+1.
REQ-020 After bit 0 of address 63, go to LATCH with no prefetch; rd_addr wraps to 0.
REQ-021 LATCH: DOUT=0 for RST_CYC cycles, then IDLE; trans falls on entry to IDLE.
REQ-022 A frame is exactly 64 words x 24 bits per line; all eight lines are bit-synchronous.
REQ-023 A read pulse while trans=1 is ignored and is not queued.
REQ-024 Cycle counter width is ceil(log2(max(TBIT_CYC,RST_CYC)+1)); it is never compared past its terminal count.
REQ-025 DOUT is registered: no combinational path from any input to DOUT.

Reset
REQ-026 On Rst_n=0, asynchronously: state=IDLE, DOUT=8'h00, trans=0, rd_en=0, rd_addr=0, counters=0, shift/holding registers=0.
REQ-027 Reset asserted mid-frame drops DOUT low immediately; after release, waits in IDLE for a new read pulse without resuming.

Structure
REQ-028 State encoding and default timing constants SHALL live in a shared package ws2812_pkg, used by this block and its bench.
REQ-029 One sub-module ws2812_bit_enc (counter plus high/low compare per bit period) SHALL be instantiated once and shared by all eight lanes through a lane-independent high-time select.

Verification
REQ-030 Reset, then read pulse; RAM model returns 24'hFF0000 on all layers at addr 0 -> first 8 bits on each DOUT are high 40 cycles/low 23, next 16 high 20/low 43.
REQ-031 Full frame with address-valued data -> exactly 1536 bit periods per line, no gap between words, then 2600 low cycles; trans high from the cycle after read until IDLE.
REQ-032 Layer k data=24'h000001<<k -> only DOUT[k] carries a '1' bit, at bit position k counted from the end; lanes stay aligned.
REQ-033 Second read pulse at bit 100 of a frame -> ignored; frame length unchanged; no second frame follows.
REQ-034 Rst_n low at word 30 -> DOUT=0 and trans=0 immediately; new read pulse -> frame restarts at rd_addr=0.
REQ-035 rd_en count per frame = 64; rd_addr sequence 0..63; no rd_en during LATCH.
